uart_tx_engine: RTL and testbench

Serial transmit engine at the far end of the controller's transmit request (tx_out -> tx_start, tx_done <- tx_done). It latches a parallel byte from the APB slave and shifts one asynchronous frame out on tx_line: start bit, data LSB first, optional parity bit, stop bit. It then holds tx_done until the controller withdraws the request, which forms a level handshake.

---
 rtl/uart_tx_engine.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// Asynchronous serial transmitter with a level tx_start/tx_done handshake.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data MSB.
module uart_tx_engine #(
   parameter int CLKS_PER_BIT = 833,
   parameter int DATA_BITS    = 8
) (
   input  logic                 ref_clk,
   input  logic                 nreset,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_line,
   output logic                 tx_done,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       baud_q, baud_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   tx_line_q, tx_line_d;
   logic                   tx_done_q, tx_done_d;
   logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   logic bit_end;

   assign bit_end = (baud_q == BAUD_LAST);

   always_ff @(posedge ref_clk) begin
      if (!nreset) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         tx_line_q <= 1'b1;
         tx_done_q <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         tx_line_q <= tx_line_d;
         tx_done_q <= tx_done_d;
         busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // tx_line_d is the level for the *next* bit period, so the line register
   // switches on the same edge as the state change and stays glitch-free.
   always_comb begin
      state_d   = state_q;
      baud_d    = bit_end ? '0 : baud_q + 1'b1;
      idx_d     = idx_q;
      shift_d   = shift_q;
      tx_line_d = tx_line_q;
      tx_done_d = tx_done_q;
      busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            baud_d    = '0;
            tx_line_d = 1'b1;
            if (tx_start) begin
               shift_d   = tx_data;
               busy_d    = 1'b1;
               tx_line_d = 1'b0;
               state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^tx_data;
`endif
            end
         end

         ST_START: begin
            if (bit_end) begin
               idx_d     = '0;
               tx_line_d = shift_q[0];
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  tx_line_d = parity_q;
                  state_d   = ST_PARITY;
`else
                  tx_line_d = 1'b1;
                  state_d   = ST_STOP;
`endif
               end else begin
                  tx_line_d = shift_q[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               tx_line_d = 1'b1;
               state_d   = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (bit_end) begin
               tx_done_d = 1'b1;
               state_d   = ST_DONE;
            end
         end

         ST_DONE: begin
            baud_d    = '0;
            tx_line_d = 1'b1;
            if (!tx_start) begin
               tx_done_d = 1'b0;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: begin
            baud_d    = '0;
            tx_line_d = 1'b1;
            tx_done_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   assign tx_line = tx_line_q;
   assign tx_done = tx_done_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomised scoreboard bench for uart_tx_engine: expected frames are queued at
// issue time and a negedge monitor checks every serial cycle against them.
module tb_uart_tx_engine;

   localparam int CPB = 4;
   localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NF  = DB + 3;
`else
   localparam int NF  = DB + 2;
`endif
   localparam int FRAME_MAX = NF * CPB + 20;

   logic          ref_clk = 1'b0;
   logic          nreset  = 1'b0;
   logic          tx_start = 1'b0;
   logic [DB-1:0] tx_data  = '0;
   logic          tx_line;
   logic          tx_done;
   logic          busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] bits;
      logic [7:0]  data;
   } exp_t;

   exp_t exp_q[$];

   uart_tx_engine #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB)
   ) dut (
      .ref_clk (ref_clk),
      .nreset  (nreset),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx_line (tx_line),
      .tx_done (tx_done),
      .busy    (busy)
   );

   always #5 ref_clk = ~ref_clk;

   // Reference frame: start 0, data LSB first, even parity (optional), stop 1.
   function automatic exp_t model(input logic [7:0] d);
      exp_t e;
      e.bits    = '1;
      e.data    = d;
      e.bits[0] = 1'b0;
      for (int i = 0; i < DB; i++) e.bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
      e.bits[DB + 1] = (($countones(d) % 2) == 1);
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: sample at negedge, pop an expectation when a start bit appears.
   bit   mon_active   = 1'b0;
   int   mon_k        = 0;
   exp_t mon_e;
   bit   rst_low_prev = 1'b0;

   always @(negedge ref_clk) begin
      if (!nreset) begin
         if (rst_low_prev) chk("reset_outs", {29'd0, tx_line, busy, tx_done}, 32'b100);
         if (mon_active) $display("frame data=%02h abandoned by reset", mon_e.data);
         mon_active   = 1'b0;
         exp_q.delete();
         rst_low_prev = 1'b1;
      end else begin
         rst_low_prev = 1'b0;
         if (!mon_active && exp_q.size() > 0 && tx_line === 1'b0) begin
            mon_e      = exp_q.pop_front();
            mon_active = 1'b1;
            mon_k      = 0;
         end
         if (mon_active) begin
            if (mon_k < NF * CPB) begin
               chk($sformatf("frame_%02h_bit%0d", mon_e.data, mon_k / CPB),
                   {29'd0, tx_line, busy, tx_done},
                   {29'd0, mon_e.bits[mon_k / CPB], 2'b10});
            end else begin
               chk($sformatf("frame_%02h_done_rise", mon_e.data),
                   {29'd0, tx_line, busy, tx_done}, 32'b111);
               $display("frame data=%02h checked over %0d cycles", mon_e.data, mon_k);
               mon_active = 1'b0;
            end
            mon_k++;
         end else if (exp_q.size() == 0) begin
            chk("idle_line", {31'd0, tx_line}, 32'd1);
         end
      end
   end

   task automatic tick();
      @(posedge ref_clk);
      #1;
   endtask

   task automatic wait_done();
      int n = 0;
      while (tx_done !== 1'b1 && n < FRAME_MAX) begin
         tick();
         n++;
      end
      chk("done_timeout", {31'd0, tx_done}, 32'd1);
   endtask

   // Issue one frame, optionally wiggle tx_start mid-frame, hold in DONE, release.
   task automatic send(input logic [7:0] d, input logic [7:0] d_after,
                       input bit wiggle, input int hold);
      tx_data  = d;
      tx_start = 1'b1;
      exp_q.push_back(model(d));
      tick();
      tx_data = d_after;
      if (wiggle) begin
         repeat ($urandom_range(1, 8)) tick();
         tx_start = 1'b0;
         repeat (3) tick();
         tx_start = 1'b1;
      end
      wait_done();
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_done", {29'd0, tx_done, tx_line, busy}, 32'b111);
      end
      tx_start = 1'b0;
      tick();
      chk("release", {29'd0, tx_done, busy, tx_line}, 32'b001);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset then idle.
      repeat (3) tick();
      nreset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_outs", {29'd0, tx_line, tx_done, busy}, 32'b100);
      end

      // Single frame, then handshake hold of 10 cycles.
      send(8'hA5, 8'hA5, 1'b0, 0);
      send(8'hA5, 8'h00, 1'b0, 10);

      // Data changed right after the accept edge.
      send(8'h3C, 8'hFF, 1'b0, 0);

      // Reset during data bit 3 of 8'h00.
      tx_data  = 8'h00;
      tx_start = 1'b1;
      exp_q.push_back(model(8'h00));
      tick();
      repeat (18) tick();
      nreset   = 1'b0;
      tx_start = 1'b0;
      repeat (2) tick();
      nreset = 1'b1;
      chk("post_reset", {30'd0, tx_line, busy}, 32'b10);
      tick();
      send(8'h81, 8'h7E, 1'b0, 0);

`ifdef UART_TX_PARITY_EN
      send(8'h07, 8'h00, 1'b0, 0);
      send(8'h03, 8'h00, 1'b0, 0);
`endif

      // Random frames with random gaps, holds and mid-frame request wiggles.
      for (int f = 0; f < 25; f++) begin
         repeat ($urandom_range(0, 3)) tick();
         send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      repeat (5) tick();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
